// File: rtl/aes_axis_tx_pkg.sv
// Shared sizing for the AES output-side stream logic.
package aes_axis_tx_pkg;

  // Result block width and stream word width.
  localparam int unsigned BlkS  = 128;
  localparam int unsigned WordW = 32;

  // Number of stream beats needed to carry one block.
  function automatic int unsigned beats_of(input int unsigned blk_w, input int unsigned word_w);
    return blk_w / word_w;
  endfunction

  localparam int unsigned Beats = beats_of(BlkS, WordW);

endpackage

// File: rtl/aes_axis_tx.sv
// Drains 128-bit result blocks from the output FIFO and serializes them onto a
// 32-bit AXI-Stream master, most significant word first. The final beat of each
// block is held back until it is known whether another block follows or the
// packet is complete, so tlast can be attached to the correct beat.
module aes_axis_tx
  import aes_axis_tx_pkg::*;
#(
  parameter int unsigned BLOCK_WIDTH = BlkS,
  parameter int unsigned WORD_WIDTH  = WordW
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    out_fifo_read_tvalid,
  output logic                    out_fifo_read_tready,
  input  logic [BLOCK_WIDTH-1:0]  out_fifo_data,
  input  logic                    processing_done,
  output logic [WORD_WIDTH-1:0]   m_axis_tdata,
  output logic [WORD_WIDTH/8-1:0] m_axis_tstrb,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    pkt_sent
);

  // BLOCK_WIDTH must be an integer multiple (>= 2) of WORD_WIDTH.
  localparam int unsigned BEATS = beats_of(BLOCK_WIDTH, WORD_WIDTH);
  localparam int unsigned CNT_W = (BEATS > 2) ? $clog2(BEATS) : 1;
  localparam int unsigned STRB_W = WORD_WIDTH / 8;
  // Handshake of this beat index ends the S_SEND phase.
  localparam logic [CNT_W-1:0] LAST_SEND_CNT = CNT_W'(BEATS - 2);

  typedef enum logic [1:0] {
    StEmpty,
    StSend,
    StDecide,
    StLast
  } state_e;

  state_e                  state_q;
  logic [BLOCK_WIDTH-1:0]  shreg_q;
  logic [CNT_W-1:0]        beat_cnt_q;
  logic                    done_prev_q;
  logic                    done_latched_q;
  logic                    tlast_r_q;

  logic pop;
  logic beat_hs;
  logic done_rise;
  logic retire;

  // Handshake, edge detect and packet-retire decode.
  always_comb begin
    pop       = out_fifo_read_tvalid & out_fifo_read_tready;
    beat_hs   = m_axis_tvalid & m_axis_tready;
    done_rise = processing_done & ~done_prev_q;
    retire    = 1'b0;
    unique case (state_q)
      StEmpty: retire = ~pop & done_latched_q & ~out_fifo_read_tvalid;
      StLast:  retire = beat_hs & tlast_r_q;
      default: retire = 1'b0;
    endcase
  end

  // Packet-complete flag: a new done edge wins over a simultaneous retire so
  // it carries over to the next packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_prev_q    <= 1'b0;
      done_latched_q <= 1'b0;
    end else begin
      done_prev_q <= processing_done;
      if (done_rise) begin
        done_latched_q <= 1'b1;
      end else if (retire) begin
        done_latched_q <= 1'b0;
      end
    end
  end

  // Serializer FSM; every output is a register updated on state transitions.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q              <= StEmpty;
      shreg_q              <= '0;
      beat_cnt_q           <= '0;
      tlast_r_q            <= 1'b0;
      out_fifo_read_tready <= 1'b0;
      m_axis_tdata         <= '0;
      m_axis_tstrb         <= '0;
      m_axis_tvalid        <= 1'b0;
      m_axis_tlast         <= 1'b0;
      pkt_sent             <= 1'b0;
    end else begin
      pkt_sent <= 1'b0;
      unique case (state_q)
        StEmpty: begin
          out_fifo_read_tready <= 1'b1;
          if (pop) begin
            shreg_q              <= out_fifo_data;
            beat_cnt_q           <= '0;
            m_axis_tdata         <= out_fifo_data[BLOCK_WIDTH-1 -: WORD_WIDTH];
            m_axis_tstrb         <= {STRB_W{1'b1}};
            m_axis_tvalid        <= 1'b1;
            m_axis_tlast         <= 1'b0;
            out_fifo_read_tready <= 1'b0;
            state_q              <= StSend;
          end else if (retire) begin
            // Packet finished with no block pending: nothing to send.
            pkt_sent <= 1'b1;
          end
        end

        StSend: begin
          if (beat_hs) begin
            shreg_q      <= shreg_q << WORD_WIDTH;
            m_axis_tdata <= shreg_q[BLOCK_WIDTH-WORD_WIDTH-1 -: WORD_WIDTH];
            beat_cnt_q   <= beat_cnt_q + CNT_W'(1);
            if (beat_cnt_q == LAST_SEND_CNT) begin
              // Hold the final word back until tlast is known.
              m_axis_tvalid <= 1'b0;
              m_axis_tstrb  <= '0;
              state_q       <= StDecide;
            end
          end
        end

        StDecide: begin
          // A waiting block means the packet continues; it is never withdrawn.
          if (out_fifo_read_tvalid) begin
            tlast_r_q     <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b1;
            m_axis_tstrb  <= {STRB_W{1'b1}};
            state_q       <= StLast;
          end else if (done_latched_q) begin
            tlast_r_q     <= 1'b1;
            m_axis_tlast  <= 1'b1;
            m_axis_tvalid <= 1'b1;
            m_axis_tstrb  <= {STRB_W{1'b1}};
            state_q       <= StLast;
          end
        end

        StLast: begin
          if (beat_hs) begin
            m_axis_tvalid        <= 1'b0;
            m_axis_tstrb         <= '0;
            m_axis_tlast         <= 1'b0;
            out_fifo_read_tready <= 1'b1;
            pkt_sent             <= tlast_r_q;
            tlast_r_q            <= 1'b0;
            state_q              <= StEmpty;
          end
        end

        default: state_q <= StEmpty;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_axis_tx.sv
// Randomized bench for aes_axis_tx: a queue-based FIFO model feeds blocks, and
// a reference queue of expected (word, last) beats is built from each packet.
module tb_aes_axis_tx;

  localparam int BW = 128;
  localparam int WW = 32;
  localparam int NB = BW / WW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          out_fifo_read_tvalid;
  logic          out_fifo_read_tready;
  logic [BW-1:0] out_fifo_data;
  logic          processing_done;
  logic [WW-1:0] m_axis_tdata;
  logic [3:0]    m_axis_tstrb;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          pkt_sent;

  always #5 clk = ~clk;

  aes_axis_tx #(
    .BLOCK_WIDTH(BW),
    .WORD_WIDTH (WW)
  ) u_dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .out_fifo_read_tvalid(out_fifo_read_tvalid),
    .out_fifo_read_tready(out_fifo_read_tready),
    .out_fifo_data       (out_fifo_data),
    .processing_done     (processing_done),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tstrb        (m_axis_tstrb),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tready       (m_axis_tready),
    .m_axis_tlast        (m_axis_tlast),
    .pkt_sent            (pkt_sent)
  );

  typedef struct packed {
    logic [WW-1:0] w;
    logic          l;
  } beat_t;

  beat_t         exp_q[$];
  logic [BW-1:0] fifo_q[$];
  int            hs_cyc[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int pkt_cnt = 0;
  int exp_total = 0;
  int exp_pkts = 0;
  int tready_pct = 100;
  bit mon_en = 1'b0;

  bit            pop_pending;
  bit            stall_prev;
  bit            pend_pkt;
  logic [WW-1:0] prev_data;
  logic          prev_last;
  beat_t         got_b;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO model, stream sink and protocol monitor.
  always begin
    @(negedge clk);
    cyc++;
    out_fifo_read_tvalid = (fifo_q.size() != 0);
    out_fifo_data        = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    pop_pending          = 1'b0;
    if (mon_en && reset_n) begin
      pop_pending = out_fifo_read_tvalid && out_fifo_read_tready;
      if (pend_pkt) begin
        check_eq("pkt_sent_after_tlast", 128'(pkt_sent), 128'(1));
        pend_pkt = 1'b0;
      end
      if (pkt_sent) pkt_cnt++;
      if (stall_prev) begin
        check_eq("stall_valid", 128'(m_axis_tvalid), 128'(1));
        check_eq("stall_data", 128'(m_axis_tdata), 128'(prev_data));
        check_eq("stall_last", 128'(m_axis_tlast), 128'(prev_last));
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      if (m_axis_tvalid) check_eq("tstrb", 128'(m_axis_tstrb), 128'(4'hf));
      if (m_axis_tvalid && m_axis_tready) begin
        hs_cnt++;
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", 128'(hs_cnt), 128'(exp_total));
        end else begin
          got_b = exp_q.pop_front();
          check_eq("tdata", 128'(m_axis_tdata), 128'(got_b.w));
          check_eq("tlast", 128'(m_axis_tlast), 128'(got_b.l));
          if (got_b.l) pend_pkt = 1'b1;
        end
      end
    end else begin
      stall_prev = 1'b0;
      pend_pkt   = 1'b0;
    end
    @(posedge clk);
    #1;
    if (pop_pending) void'(fifo_q.pop_front());
    m_axis_tready = (int'($urandom_range(99)) < tready_pct);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue one block and its expected beats: word i is bits [BW-1-32i -: 32].
  task automatic push_block(input logic [BW-1:0] b, input bit last_of_pkt);
    beat_t x;
    fifo_q.push_back(b);
    for (int i = 0; i < NB; i++) begin
      x.w = WW'((b >> (WW * (NB - 1 - i))) & {{(BW-WW){1'b0}}, {WW{1'b1}}});
      x.l = last_of_pkt && (i == NB - 1);
      exp_q.push_back(x);
      exp_total++;
    end
  endtask

  function automatic logic [BW-1:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_pkts(input int target, input int budget);
    int n = 0;
    while (pkt_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq("pkt_cnt", 128'(pkt_cnt), 128'(target));
  endtask

  // Push a packet's blocks (optionally spaced out), then signal done.
  task automatic run_packet(input int nblk, input bit gaps);
    for (int k = 0; k < nblk; k++) begin
      push_block(rand_block(), k == nblk - 1);
      if (gaps) step($urandom_range(0, 8));
    end
    processing_done = 1'b1;
    exp_pkts++;
    wait_pkts(exp_pkts, 3000);
    check_eq("exp_drained", 128'(exp_q.size()), 128'(0));
    processing_done = 1'b0;
    step(2);
  endtask

  initial begin
    int lat;
    int h0;
    int low;
    int n;
    reset_n         = 1'b0;
    processing_done = 1'b0;
    m_axis_tready   = 1'b0;
    step(3);
    check_eq("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    check_eq("rst_tready", 128'(out_fifo_read_tready), 128'(0));
    check_eq("rst_tlast", 128'(m_axis_tlast), 128'(0));
    check_eq("rst_tdata_tstrb_pkt", 128'({m_axis_tdata, m_axis_tstrb, pkt_sent}), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    step(3);

    // 1: single fixed block, latency from FIFO valid to first beat
    tready_pct = 100;
    step(1);
    push_block(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_axis_tvalid && lat < 20);
    check_eq("latency", 128'(lat), 128'(2));
    step(1);
    processing_done = 1'b1;
    exp_pkts++;
    wait_pkts(exp_pkts, 200);
    check_eq("exp_drained", 128'(exp_q.size()), 128'(0));
    processing_done = 1'b0;
    step(2);

    // 2: three pre-filled blocks, one packet, full-rate throughput
    h0 = hs_cyc.size();
    run_packet(3, 1'b0);
    check_eq("thru", 128'((hs_cyc[h0 + 3*NB - 1] - hs_cyc[h0]) <= 3 * (NB + 2) - 2), 128'(1));

    // 3: done held off; last beat waits with tvalid low
    h0 = hs_cnt;
    push_block(rand_block(), 1'b1);
    step(12);
    check_eq("beats_before_done", 128'(hs_cnt - h0), 128'(NB - 1));
    low = 0;
    repeat (20) begin
      @(negedge clk);
      if (!m_axis_tvalid) low++;
    end
    check_eq("decide_hold", 128'(low), 128'(20));
    step(1);
    processing_done = 1'b1;
    exp_pkts++;
    wait_pkts(exp_pkts, 200);
    check_eq("exp_drained", 128'(exp_q.size()), 128'(0));
    processing_done = 1'b0;
    step(2);

    // 4: random back-pressure over four blocks
    tready_pct = 50;
    run_packet(4, 1'b0);
    tready_pct = 100;

    // 5: done with an empty FIFO retires a zero-block packet
    h0 = hs_cnt;
    processing_done = 1'b1;
    exp_pkts++;
    wait_pkts(exp_pkts, 50);
    step(5);
    check_eq("zero_block_beats", 128'(hs_cnt - h0), 128'(0));
    check_eq("zero_block_once", 128'(pkt_cnt), 128'(exp_pkts));
    processing_done = 1'b0;
    step(2);
    run_packet(1, 1'b0);

    // 6: asynchronous reset in the middle of a block
    h0 = hs_cnt;
    push_block(rand_block(), 1'b1);
    n = 0;
    while (hs_cnt < h0 + 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    #2;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    check_eq("async_rst_outs",
             128'({m_axis_tdata, m_axis_tstrb, m_axis_tlast, out_fifo_read_tready, pkt_sent}),
             128'(0));
    exp_q.delete();
    fifo_q.delete();
    step(2);
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    step(3);
    exp_total = hs_cnt;
    run_packet(2, 1'b0);

    // Random packets: varying size, spacing and back-pressure
    for (int p = 0; p < 20; p++) begin
      case ($urandom_range(2))
        0: tready_pct = 100;
        1: tready_pct = 70;
        default: tready_pct = 40;
      endcase
      run_packet(int'($urandom_range(1, 4)), bit'($urandom_range(1)));
    end

    step(10);
    check_eq("pkts_total", 128'(pkt_cnt), 128'(exp_pkts));
    check_eq("beats_total", 128'(hs_cnt), 128'(exp_total));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
